// File: rtl/uart_frame_parser.sv
// Frame parser behind a byte receiver: hunts SOF, collects a length-prefixed payload,
// checks an XOR checksum and streams the verified payload out on a ready/valid port.
module uart_frame_parser #(
    parameter logic [7:0] SOF     = 8'h55,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       ap_rst,
    output logic       rx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [2:0] dbg_frame_state_o,
    output logic [1:0] dbg_fetch_state_o
);
    // Handshakes: a beat moves on m_valid && m_ready; once m_valid is high, m_data and
    // m_last stay put until accepted. On the receiver side rx_valid is a level that
    // stays high until rx_ready re-arms it, and a byte is taken only in F_WAIT.
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {F_REQ, F_WAIT, F_REL} fetch_t;
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} frame_t;

    fetch_t        fetch_q;
    logic          rel_cnt_q;
    logic          rx_ready_q;
    frame_t        frame_q;
    logic [LW-1:0] len_q;
    logic [7:0]    chk_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] to_cnt_q;
    logic [7:0]    mem_q [MAX_LEN];
    logic [7:0]    m_data_q;
    logic          m_valid_q, m_last_q, frame_ok_q, frame_err_q;
    logic [1:0]    err_code_q;

    logic byte_stb, counting, to_fire;
    logic [PW-1:0] rd_next;

    assign byte_stb = (fetch_q == F_WAIT) && rx_valid;
    assign counting = (frame_q == LEN) || (frame_q == PAYLOAD) || (frame_q == CHK);
    // A byte arriving in the same cycle as the timeout wins.
    assign to_fire  = counting && !byte_stb && (to_cnt_q == TO_LAST);
    assign rd_next  = rd_ptr_q + PW'(1);

    always_ff @(posedge clk) begin
        if (ap_rst) begin
            fetch_q    <= F_REQ;
            rel_cnt_q  <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            case (fetch_q)
                F_REQ: begin
                    rx_ready_q <= 1'b1;
                    if (!rx_valid) fetch_q <= F_WAIT;
                end
                F_WAIT: begin
                    rx_ready_q <= 1'b1;
                    if (rx_valid) begin
                        fetch_q    <= F_REL;
                        rx_ready_q <= 1'b0;
                        rel_cnt_q  <= 1'b0;
                    end
                end
                F_REL: begin
                    rx_ready_q <= 1'b0;
                    if (!rel_cnt_q) begin
                        rel_cnt_q <= 1'b1;
                    end else if (frame_q != DRAIN) begin
                        fetch_q    <= F_REQ;
                        rx_ready_q <= 1'b1;
                    end
                end
                default: fetch_q <= F_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ap_rst) begin
            frame_q     <= HUNT;
            len_q       <= '0;
            chk_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            to_cnt_q    <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (byte_stb || !counting || to_fire) to_cnt_q <= '0;
            else                                  to_cnt_q <= to_cnt_q + CW'(1);

            if (to_fire) begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd3;
                frame_q     <= HUNT;
            end else begin
                case (frame_q)
                    HUNT: if (byte_stb && rx_data == SOF) frame_q <= LEN;
                    LEN: if (byte_stb) begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd1;
                            frame_q     <= HUNT;
                        end else begin
                            len_q    <= rx_data[LW-1:0];
                            chk_q    <= rx_data;
                            wr_ptr_q <= '0;
                            frame_q  <= PAYLOAD;
                        end
                    end
                    PAYLOAD: if (byte_stb) begin
                        mem_q[wr_ptr_q] <= rx_data;
                        chk_q           <= chk_q ^ rx_data;
                        wr_ptr_q        <= wr_ptr_q + PW'(1);
                        if (LW'(wr_ptr_q) == len_q - LW'(1)) frame_q <= CHK;
                    end
                    CHK: if (byte_stb) begin
                        if (rx_data == chk_q) begin
                            frame_ok_q <= 1'b1;
                            rd_ptr_q   <= '0;
                            m_valid_q  <= 1'b1;
                            m_data_q   <= mem_q[0];
                            m_last_q   <= (len_q == LW'(1));
                            frame_q    <= DRAIN;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd2;
                            frame_q     <= HUNT;
                        end
                    end
                    DRAIN: if (m_ready) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            frame_q   <= HUNT;
                        end else begin
                            rd_ptr_q <= rd_next;
                            m_data_q <= mem_q[rd_next];
                            m_last_q <= (LW'(rd_next) == len_q - LW'(1));
                        end
                    end
                    default: frame_q <= HUNT;
                endcase
            end
        end
    end

    assign rx_ready          = rx_ready_q;
    assign m_data            = m_data_q;
    assign m_valid           = m_valid_q;
    assign m_last            = m_last_q;
    assign frame_ok          = frame_ok_q;
    assign frame_err         = frame_err_q;
    assign err_code          = err_code_q;
    assign dbg_frame_state_o = frame_q;
    assign dbg_fetch_state_o = fetch_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: drives the receiver handshake byte by byte
// and checks pulses, error codes and payload beats against hand-computed values.
module tb_uart_frame_parser;
    logic       clk = 1'b0;
    logic       ap_rst;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [2:0] dbg_frame_state;
    logic [1:0] dbg_fetch_state;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int mv_cnt = 0;
    int excl_viol = 0;

    always #5 clk = ~clk;

    uart_frame_parser #(.SOF(8'h55), .MAX_LEN(16), .TIMEOUT(100)) dut (
        .clk(clk), .ap_rst(ap_rst), .rx_ready(rx_ready), .rx_valid(rx_valid),
        .rx_data(rx_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .dbg_frame_state_o(dbg_frame_state), .dbg_fetch_state_o(dbg_fetch_state)
    );

    always @(negedge clk) begin
        if (!ap_rst) begin
            if (frame_ok) ok_cnt++;
            if (frame_err) err_cnt++;
            if (m_valid) mv_cnt++;
            if (frame_ok && frame_err) excl_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: re-arm drops rx_valid, then a new byte is presented and held.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 500) begin
            tick();
            n++;
        end
        chk("rx_ready_arm", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] d, input logic last);
        int n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"}, 32'(m_data), 32'(d));
        chk({tag, "_last"}, 32'(m_last), 32'(last));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        if (last) chk({tag, "_done"}, 32'(m_valid), 32'd0);
    endtask

    logic [7:0] fr[$];
    int n;
    int bad;
    int base_err;
    int base_ok;
    int base_mv;

    initial begin
        ap_rst   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_ready  = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({rx_ready, m_valid, m_last, frame_ok, frame_err, err_code, m_data}), 32'd0);
        ap_rst = 1'b0;
        tick();
        chk("rx_ready_after_reset", 32'(rx_ready), 32'd1);

        // Good frame: chk = 03^11^22^33 = 03
        base_ok = ok_cnt;
        fr = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_bytes(fr);
        chk("good_ok", 32'(frame_ok), 32'd1);
        chk("good_no_err", 32'(frame_err), 32'd0);
        expect_beat("good0", 8'h11, 1'b0);
        expect_beat("good1", 8'h22, 1'b0);
        expect_beat("good2", 8'h33, 1'b1);
        chk("good_ok_once", 32'(ok_cnt - base_ok), 32'd1);
        chk("good_err_code", 32'(err_code), 32'd0);

        // Bad checksum: 02^AA^BB = 13, sent 00
        base_mv = mv_cnt;
        fr = '{8'h55, 8'h02, 8'hAA, 8'hBB, 8'h00};
        send_bytes(fr);
        chk("badchk_err", 32'(frame_err), 32'd1);
        chk("badchk_code", 32'(err_code), 32'd2);
        tick();
        chk("badchk_no_valid", 32'(mv_cnt - base_mv), 32'd0);
        fr = '{8'h55, 8'h01, 8'h7E, 8'h7F};
        send_bytes(fr);
        chk("after_badchk_ok", 32'(frame_ok), 32'd1);
        expect_beat("single", 8'h7E, 1'b1);

        // Length errors
        fr = '{8'h55, 8'h00};
        send_bytes(fr);
        chk("len0_err", 32'(frame_err), 32'd1);
        chk("len0_code", 32'(err_code), 32'd1);
        fr = '{8'h55, 8'h11};
        send_bytes(fr);
        chk("len17_err", 32'(frame_err), 32'd1);
        chk("len17_code", 32'(err_code), 32'd1);
        fr = '{8'h55, 8'h01, 8'h42, 8'h43};
        send_bytes(fr);
        chk("after_len_ok", 32'(frame_ok), 32'd1);
        expect_beat("len_recover", 8'h42, 1'b1);
        chk("err_code_held", 32'(err_code), 32'd1);

        // Garbage before SOF: chk = 02^01^02 = 01
        base_err = err_cnt;
        fr = '{8'h00, 8'hFF, 8'h13, 8'h55, 8'h02, 8'h01, 8'h02, 8'h01};
        send_bytes(fr);
        chk("garbage_ok", 32'(frame_ok), 32'd1);
        chk("garbage_no_err", 32'(err_cnt - base_err), 32'd0);
        expect_beat("garb0", 8'h01, 1'b0);
        expect_beat("garb1", 8'h02, 1'b1);

        // Backpressure: chk = 04^A1^B2^C3^D4 = 00
        fr = '{8'h55, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00};
        send_bytes(fr);
        chk("bp_ok", 32'(frame_ok), 32'd1);
        expect_beat("bp0", 8'hA1, 1'b0);
        bad = 0;
        repeat (10) begin
            if (!(m_valid && m_data == 8'hB2 && !m_last && !rx_ready)) bad++;
            tick();
        end
        chk("bp_hold", 32'(bad), 32'd0);
        expect_beat("bp1", 8'hB2, 1'b0);
        chk("bp_rx_ready_low", 32'(rx_ready), 32'd0);
        expect_beat("bp2", 8'hC3, 1'b0);
        expect_beat("bp3", 8'hD4, 1'b1);

        // Timeout: 100 idle cycles elapse after the byte, pulse shows on the next one
        fr = '{8'h55, 8'h02, 8'h10};
        send_bytes(fr);
        n = 1;
        while (!frame_err && n < 300) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd101);
        chk("timeout_code", 32'(err_code), 32'd3);
        fr = '{8'h55, 8'h01, 8'h42, 8'h43};
        send_bytes(fr);
        chk("after_timeout_ok", 32'(frame_ok), 32'd1);
        expect_beat("to_recover", 8'h42, 1'b1);

        // Reset mid-payload
        fr = '{8'h55, 8'h03, 8'h01, 8'h02};
        send_bytes(fr);
        ap_rst = 1'b1;
        tick();
        chk("midreset_outputs", 32'({rx_ready, m_valid, m_last, frame_ok, frame_err, err_code, m_data}), 32'd0);
        ap_rst = 1'b0;
        base_err = err_cnt;
        fr = '{8'h55, 8'h02, 8'h01, 8'h02, 8'h01};
        send_bytes(fr);
        chk("after_reset_ok", 32'(frame_ok), 32'd1);
        expect_beat("rst0", 8'h01, 1'b0);
        expect_beat("rst1", 8'h02, 1'b1);
        chk("after_reset_no_err", 32'(err_cnt - base_err), 32'd0);

        chk("ok_err_exclusive", 32'(excl_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
